// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } mem_state_e;

  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/data_memory.sv
// Single-port word memory: synchronous write, combinational read, no reset.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk)
    if (we) mem_q[addr] <= wdata;

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: wait-state FSM, freeze generation, data memory and MEM/WB register.
// Optional address range checking is enabled with MEM_STAGE_ADDR_CHECK_EN.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 4,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              freeze,
  output logic              wb_en_MA_reg,
  output logic              mem_r_en_MA_reg,
  output logic [REG_W-1:0]  dest_MA_reg,
  output logic [DATA_W-1:0] alu_res_MA_reg,
  output logic [DATA_W-1:0] mem_data_MA_reg,
  output logic              addr_err
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WAIT_LOAD = (WAIT_CYCLES >= 2) ? WAIT_CYCLES - 2 : 0;

  mem_state_e        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              mem_op, done, bad_addr, mem_we;
  logic [DATA_W-1:0] idx_full, rdata;
  logic [AW-1:0]     idx;

  assign mem_op   = mem_r_en_in | mem_w_en_in;
  assign idx_full = (alu_res_in - DATA_W'(BASE_ADDR)) >> 2;
  assign idx      = AW'(idx_full % DATA_W'(DEPTH));

`ifdef MEM_STAGE_ADDR_CHECK_EN
  assign bad_addr = (alu_res_in < DATA_W'(BASE_ADDR)) || (idx_full >= DATA_W'(DEPTH));
`else
  assign bad_addr = 1'b0;
`endif

  // The IDLE cycle that sees the op is itself the first wait state, so an op
  // occupies IDLE + (WAIT_CYCLES-1) wait cycles + ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          if (WAIT_CYCLES == 0) begin
            done = 1'b1;
          end else begin
            freeze = 1'b1;
            if (WAIT_CYCLES == 1) begin
              state_d = ST_ACCESS;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_LOAD;
            end
          end
        end
      end
      ST_WAIT: begin
        freeze = 1'b1;
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - 32'd1;
      end
      ST_ACCESS: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_we = done & mem_w_en_in & ~bad_addr;

  data_memory #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx),
    .wdata (val_rm_in),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      wb_en_MA_reg    <= 1'b0;
      mem_r_en_MA_reg <= 1'b0;
      dest_MA_reg     <= '0;
      alu_res_MA_reg  <= '0;
      mem_data_MA_reg <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (freeze) begin
        // Bubble to WB and forwarding; data fields keep their last value.
        wb_en_MA_reg    <= 1'b0;
        mem_r_en_MA_reg <= 1'b0;
        dest_MA_reg     <= '0;
      end else begin
        wb_en_MA_reg    <= wb_en_in;
        mem_r_en_MA_reg <= mem_r_en_in;
        dest_MA_reg     <= dest_in;
        alu_res_MA_reg  <= alu_res_in;
        if (done) mem_data_MA_reg <= (mem_w_en_in | bad_addr) ? '0 : rdata;
      end
    end
  end

`ifdef MEM_STAGE_ADDR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   err_q <= 1'b0;
    else if (done && bad_addr) err_q <= 1'b1;
  end
  assign addr_err = err_q;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 side instance).
module tb_mem_stage_ctrl;

  localparam int          WC    = 2;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd1024;
`ifdef MEM_STAGE_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        freeze, wb_en_MA_reg, mem_r_en_MA_reg, addr_err;
  logic [3:0]  dest_MA_reg;
  logic [31:0] alu_res_MA_reg, mem_data_MA_reg;

  logic        z_wb, z_re, z_we;
  logic [31:0] z_alu, z_val;
  logic [3:0]  z_dest;
  logic        z_freeze, z_wb_o, z_re_o, z_err;
  logic [3:0]  z_dest_o;
  logic [31:0] z_alu_o, z_md_o;

  mem_stage_ctrl #(.DATA_W(32), .REG_W(4), .DEPTH(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
    .dest_in(dest_in), .freeze(freeze), .wb_en_MA_reg(wb_en_MA_reg),
    .mem_r_en_MA_reg(mem_r_en_MA_reg), .dest_MA_reg(dest_MA_reg),
    .alu_res_MA_reg(alu_res_MA_reg), .mem_data_MA_reg(mem_data_MA_reg), .addr_err(addr_err)
  );

  mem_stage_ctrl #(.DATA_W(32), .REG_W(4), .DEPTH(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wb_en_in(z_wb), .mem_r_en_in(z_re),
    .mem_w_en_in(z_we), .alu_res_in(z_alu), .val_rm_in(z_val),
    .dest_in(z_dest), .freeze(z_freeze), .wb_en_MA_reg(z_wb_o),
    .mem_r_en_MA_reg(z_re_o), .dest_MA_reg(z_dest_o),
    .alu_res_MA_reg(z_alu_o), .mem_data_MA_reg(z_md_o), .addr_err(z_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: word memory plus the architectural MEM/WB contents.
  logic [31:0] ref_a [DEPTH];
  logic [31:0] ref_z [DEPTH];
  logic        e_wb, e_re, e_err;
  logic [3:0]  e_dest;
  logic [31:0] e_alu, e_md;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return CHK_EN && ((a < BASE) || (((a - BASE) >> 2) >= 32'(DEPTH)));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % 32'(DEPTH));
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".wb_en"},   32'(wb_en_MA_reg),    32'(e_wb));
    chk({tag, ".mem_r"},   32'(mem_r_en_MA_reg), 32'(e_re));
    chk({tag, ".dest"},    32'(dest_MA_reg),     32'(e_dest));
    chk({tag, ".alu_res"}, alu_res_MA_reg,       e_alu);
    chk({tag, ".mem_data"}, mem_data_MA_reg,     e_md);
    chk({tag, ".addr_err"}, 32'(addr_err),       32'(e_err));
  endtask

  // Called 1 time unit after a rising edge; leaves the op's inputs applied.
  task automatic mem_op(input string tag, input logic re, input logic we, input logic wb,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] dest);
    bit memop;
    wb_en_in = wb; mem_r_en_in = re; mem_w_en_in = we;
    alu_res_in = addr; val_rm_in = data; dest_in = dest;
    memop = re | we;
    if (memop) begin
      for (int k = 0; k < WC; k++) begin
        #1 chk({tag, ".freeze_hi"}, 32'(freeze), 32'd1);
        @(posedge clk); #1;
        e_wb = 1'b0; e_re = 1'b0; e_dest = 4'd0;
        check_outs({tag, ".bubble"});
      end
    end
    #1 chk({tag, ".freeze_lo"}, 32'(freeze), 32'd0);
    @(posedge clk); #1;
    e_wb = wb; e_re = re; e_dest = dest; e_alu = addr;
    if (memop) begin
      if (is_bad(addr)) e_err = 1'b1;
      if (we) begin
        if (!is_bad(addr)) ref_a[widx(addr)] = data;
        e_md = '0;
      end else begin
        e_md = is_bad(addr) ? 32'd0 : ref_a[widx(addr)];
      end
    end
    check_outs({tag, ".done"});
  endtask

  task automatic z_op(input string tag, input logic re, input logic we,
                      input logic [31:0] addr, input logic [31:0] data, input logic [3:0] dest);
    logic [31:0] exp_md;
    z_wb = 1'b1; z_re = re; z_we = we; z_alu = addr; z_val = data; z_dest = dest;
    #1 chk({tag, ".freeze"}, 32'(z_freeze), 32'd0);
    exp_md = z_md_o;
    if (we) begin ref_z[widx(addr)] = data; exp_md = '0; end
    else if (re) exp_md = ref_z[widx(addr)];
    @(posedge clk); #1;
    chk({tag, ".dest"}, 32'(z_dest_o), 32'(dest));
    chk({tag, ".wb_en"}, 32'(z_wb_o), 32'd1);
    chk({tag, ".mem_data"}, z_md_o, exp_md);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int kind;
    rst = 1'b1;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; alu_res_in = 0; val_rm_in = 0; dest_in = 0;
    z_wb = 0; z_re = 0; z_we = 0; z_alu = 0; z_val = 0; z_dest = 0;
    e_wb = 0; e_re = 0; e_err = 0; e_dest = 0; e_alu = 0; e_md = 0;
    #2;
    check_outs("reset");
    chk("reset.freeze", 32'(freeze), 32'd0);
    chk("reset.z_md", z_md_o, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait instance: one result per cycle, never frozen.
    for (int i = 0; i < 3; i++) z_op("z_st", 1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'(i + 1));
    for (int i = 0; i < 3; i++) z_op("z_ld", 1'b1, 1'b0, BASE + 32'(4 * i), 32'd0, 4'(i + 8));
    z_wb = 0; z_re = 0; z_we = 0;

    for (int i = 0; i < DEPTH; i++)
      mem_op("init", 1'b0, 1'b1, 1'b0, BASE + 32'(4 * i), $urandom, 4'($urandom_range(0, 15)));

    mem_op("alu", 1'b0, 1'b0, 1'b1, 32'd7, 32'd0, 4'd5);
    mem_op("st_dead", 1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd3);
    mem_op("ld_dead", 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd9);
    chk("ld_dead.value", mem_data_MA_reg, 32'hDEADBEEF);
    mem_op("rw_both", 1'b1, 1'b1, 1'b1, 32'd1040, 32'h12345678, 4'd2);
    mem_op("ld_both", 1'b1, 1'b0, 1'b1, 32'd1042, 32'd0, 4'd4);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      d = $urandom;
      if (kind == 0) a = $urandom;
      mem_op("rand", kind[0], kind[1], 1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)));
    end

    mem_op("st_oor", 1'b0, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h5A5A5A5A, 4'd1);
    mem_op("ld_w0", 1'b1, 1'b0, 1'b1, BASE, 32'd0, 4'd6);
    mem_op("ld_below", 1'b1, 1'b0, 1'b1, BASE - 32'd4, 32'd0, 4'd7);
    mem_op("alu_sticky", 1'b0, 1'b0, 1'b1, 32'd99, 32'd0, 4'd8);

    // Abort a store in its wait phase and verify word 0 is untouched.
    mem_op("st_w0", 1'b0, 1'b1, 1'b0, BASE, 32'h11111111, 4'd1);
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 1; alu_res_in = BASE; val_rm_in = 32'hCAFEF00D; dest_in = 4'd2;
    @(posedge clk); #1;
    chk("abort.freeze_wait", 32'(freeze), 32'd1);
    rst = 1'b1;
    #1;
    e_wb = 0; e_re = 0; e_err = 0; e_dest = 0; e_alu = 0; e_md = 0;
    check_outs("abort.reset");
    mem_w_en_in = 0; alu_res_in = 0; val_rm_in = 0; dest_in = 0;
    #1 chk("abort.freeze_idle", 32'(freeze), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_outs("abort.post");
    mem_op("abort.ld_w0", 1'b1, 1'b0, 1'b1, BASE, 32'd0, 4'd3);
    chk("abort.w0_kept", mem_data_MA_reg, 32'h11111111);

    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
